// File: rtl/store_write_coalescer.sv
// store_write_coalescer
//   Merges consecutive committed stores that hit the same XLEN-aligned word
//   into one entry, then issues that entry to the D$ write port with req/gnt.
//
//   Ports:
//     clk_i, rst_ni          clock, async active-low reset
//     drain_i                close the open entry and issue it now
//     empty_o                no entry held and no request outstanding
//     valid_i/ready_o        committed store handshake
//     paddr_i/data_i/be_i/size_i   store payload (data pre-aligned to word)
//     req_o/gnt_i            D$ write handshake
//     addr_o/wdata_o/be_o/size_o   D$ write payload (zero unless req_o)
//
//   Optional: define STORE_COALESCE_STATS_EN to add stat_merges_o and
//   stat_issues_o (32-bit saturating event counters).
module store_write_coalescer #(
    parameter int unsigned PLEN    = 56,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              drain_i,
    output logic              empty_o,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [PLEN-1:0]   paddr_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [1:0]        size_i,
    output logic              req_o,
    input  logic              gnt_i,
    output logic [PLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [1:0]        size_o
`ifdef STORE_COALESCE_STATS_EN
    ,
    output logic [31:0]       stat_merges_o,
    output logic [31:0]       stat_issues_o
`endif
);

    localparam int unsigned BEW = XLEN / 8;
    localparam int unsigned OFF = $clog2(BEW);
    // Keep the timer at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OPEN, ISSUE} state_e;

    state_e                 state_q, state_d;
    logic [PLEN-OFF-1:0]    waddr_q, waddr_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [BEW-1:0]         be_q, be_d;
    logic [1:0]             size_q, size_d;
    logic                   merged_q, merged_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic match, close, merge, grant;

    // Byte offset bits only select lanes, which be_i already encodes.
    logic unused_addr_lo;
    assign unused_addr_lo = ^paddr_i[OFF-1:0];

    assign match = valid_i && (paddr_i[PLEN-1:OFF] == waddr_q);

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        data_d   = data_q;
        be_d     = be_q;
        size_d   = size_q;
        merged_d = merged_q;
        timer_d  = timer_q;
        ready_o  = 1'b0;
        empty_o  = 1'b0;
        req_o    = 1'b0;
        addr_o   = '0;
        wdata_o  = '0;
        be_o     = '0;
        size_o   = '0;
        close    = 1'b0;
        merge    = 1'b0;
        grant    = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                empty_o = 1'b1;
                if (valid_i) begin
                    waddr_d  = paddr_i[PLEN-1:OFF];
                    data_d   = data_i;
                    be_d     = be_i;
                    size_d   = size_i;
                    merged_d = 1'b0;
                    timer_d  = '0;
                    state_d  = (TIMEOUT > 0) ? OPEN : ISSUE;
                end
            end
            OPEN: begin
                // Close has priority: a matching store that arrives together
                // with drain or the timeout is held back, not merged.
                close   = drain_i || (timer_q == TMAX) || (valid_i && !match);
                ready_o = match && !drain_i && (timer_q != TMAX);
                if (close) begin
                    state_d = ISSUE;
                    timer_d = '0;
                end else if (ready_o) begin
                    merge    = 1'b1;
                    merged_d = 1'b1;
                    timer_d  = '0;
                    be_d     = be_q | be_i;
                    for (int k = 0; k < BEW; k++) begin
                        if (be_i[k]) data_d[8*k +: 8] = data_i[8*k +: 8];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ISSUE: begin
                req_o   = 1'b1;
                addr_o  = {waddr_q, {OFF{1'b0}}};
                wdata_o = data_q;
                be_o    = be_q;
                // A merged entry may span several sizes; issue as a full
                // word and let the byte enables mask it.
                size_o  = merged_q ? 2'd3 : size_q;
                if (gnt_i) begin
                    grant    = 1'b1;
                    state_d  = IDLE;
                    waddr_d  = '0;
                    data_d   = '0;
                    be_d     = '0;
                    size_d   = '0;
                    merged_d = 1'b0;
                    timer_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            waddr_q  <= '0;
            data_q   <= '0;
            be_q     <= '0;
            size_q   <= '0;
            merged_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            size_q   <= size_d;
            merged_q <= merged_d;
            timer_q  <= timer_d;
        end
    end

`ifdef STORE_COALESCE_STATS_EN
    logic [31:0] merges_q, merges_d, issues_q, issues_d;

    always_comb begin
        merges_d = merges_q;
        issues_d = issues_q;
        if (merge && (merges_q != '1)) merges_d = merges_q + 32'd1;
        if (grant && (issues_q != '1)) issues_d = issues_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            merges_q <= '0;
            issues_q <= '0;
        end else begin
            merges_q <= merges_d;
            issues_q <= issues_d;
        end
    end

    assign stat_merges_o = merges_q;
    assign stat_issues_o = issues_q;
`else
    logic unused_stats;
    assign unused_stats = merge ^ grant;
`endif

endmodule

// File: tb/tb_store_write_coalescer.sv
// Directed bench for store_write_coalescer (PLEN=56, XLEN=64, TIMEOUT=8).
module tb_store_write_coalescer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        drain_i = 1'b0;
    logic        empty_o;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [55:0] paddr_i = '0;
    logic [63:0] data_i = '0;
    logic [7:0]  be_i = '0;
    logic [1:0]  size_i = '0;
    logic        req_o;
    logic        gnt_i = 1'b1;
    logic [55:0] addr_o;
    logic [63:0] wdata_o;
    logic [7:0]  be_o;
    logic [1:0]  size_o;
`ifdef STORE_COALESCE_STATS_EN
    logic [31:0] stat_merges_o, stat_issues_o;
`endif

    int tests = 0;
    int fails = 0;

    store_write_coalescer #(.PLEN(56), .XLEN(64), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .drain_i(drain_i), .empty_o(empty_o),
        .valid_i(valid_i), .ready_o(ready_o), .paddr_i(paddr_i), .data_i(data_i),
        .be_i(be_i), .size_i(size_i), .req_o(req_o), .gnt_i(gnt_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o)
`ifdef STORE_COALESCE_STATS_EN
        , .stat_merges_o(stat_merges_o), .stat_issues_o(stat_issues_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [55:0] a, input logic [63:0] d,
                       input logic [7:0] be, input logic [1:0] sz);
        valid_i = 1'b1; paddr_i = a; data_i = d; be_i = be; size_i = sz;
    endtask

    task automatic idle_in();
        valid_i = 1'b0; paddr_i = '0; data_i = '0; be_i = '0; size_i = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", ready_o); end
        tests++; if (req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", req_o); end
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b want 1", empty_o); end
        tests++; if ({addr_o, wdata_o, be_o, size_o} !== '0) begin fails++; $display("FAIL reset_outputs got %h/%h/%h/%h want 0", addr_o, wdata_o, be_o, size_o); end
`ifdef STORE_COALESCE_STATS_EN
        tests++; if ({stat_merges_o, stat_issues_o} !== 64'd0) begin fails++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_merges_o, stat_issues_o); end
`endif
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single_timeout();
        int n;
        gnt_i = 1'b1;
        put(56'h1000, 64'h1122334455667788, 8'hFF, 2'd3);
        step();
        idle_in();
        #1;
        tests++; if (empty_o !== 1'b0) begin fails++; $display("FAIL single_empty_open got %0b want 0", empty_o); end
        n = 1;
        while (!req_o && n < 20) begin step(); n++; end
        tests++; if (n !== 10) begin fails++; $display("FAIL single_latency got %0d want 10", n); end
        tests++; if (addr_o !== 56'h1000 || be_o !== 8'hFF || size_o !== 2'd3) begin fails++; $display("FAIL single_payload got %h/%h/%0d want 1000/ff/3", addr_o, be_o, size_o); end
        tests++; if (wdata_o !== 64'h1122334455667788) begin fails++; $display("FAIL single_wdata got %h want 1122334455667788", wdata_o); end
        step();
        tests++; if (empty_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL single_freed got empty=%0b req=%0b want 1/0", empty_o, req_o); end
    endtask

    task automatic test_merge_drain();
        put(56'h2001, 64'h0000_0000_0000_AA00, 8'h02, 2'd0);
        step();
        put(56'h2006, 64'h00BB_0000_0000_0000, 8'h40, 2'd0);
        #1;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL merge_ready got %0b want 1", ready_o); end
        step();
        idle_in();
        drain_i = 1'b1;
        step();
        drain_i = 1'b0;
        #1;
        tests++; if (req_o !== 1'b1 || addr_o !== 56'h2000 || be_o !== 8'h42 || size_o !== 2'd3) begin fails++; $display("FAIL merge_payload got req=%0b %h/%h/%0d want 1 2000/42/3", req_o, addr_o, be_o, size_o); end
        tests++; if (wdata_o !== 64'h00BB_0000_0000_AA00) begin fails++; $display("FAIL merge_wdata got %h want 00bb00000000aa00", wdata_o); end
        step();
    endtask

    task automatic test_back_to_back();
        gnt_i = 1'b0;
        put(56'h3000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'd2);
        step();
        put(56'h3008, 64'h0000_0000_CAFE_F00D, 8'h0F, 2'd2);
        #1;
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL b2b_ready_open got %0b want 0", ready_o); end
        step();
        tests++; if (req_o !== 1'b1 || addr_o !== 56'h3000 || be_o !== 8'h0F || size_o !== 2'd2 || ready_o !== 1'b0) begin fails++; $display("FAIL b2b_first got req=%0b rdy=%0b %h/%h/%0d want 1 0 3000/0f/2", req_o, ready_o, addr_o, be_o, size_o); end
        gnt_i = 1'b1;
        step();
        tests++; if (ready_o !== 1'b1 || empty_o !== 1'b1) begin fails++; $display("FAIL b2b_idle got rdy=%0b empty=%0b want 1/1", ready_o, empty_o); end
        step();
        idle_in();
        drain_i = 1'b1;
        step();
        drain_i = 1'b0;
        #1;
        tests++; if (req_o !== 1'b1 || addr_o !== 56'h3008 || size_o !== 2'd2 || wdata_o !== 64'h0000_0000_CAFE_F00D) begin fails++; $display("FAIL b2b_second got req=%0b %h/%0d/%h want 1 3008/2/cafef00d", req_o, addr_o, size_o, wdata_o); end
        step();
    endtask

    task automatic test_gnt_stall();
        gnt_i = 1'b0;
        put(56'h4000, 64'h0102030405060708, 8'hFF, 2'd3);
        step();
        idle_in();
        drain_i = 1'b1;
        step();
        drain_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++; if (req_o !== 1'b1 || addr_o !== 56'h4000 || wdata_o !== 64'h0102030405060708 || be_o !== 8'hFF || size_o !== 2'd3) begin fails++; $display("FAIL stall_hold[%0d] got req=%0b %h/%h/%h/%0d", i, req_o, addr_o, wdata_o, be_o, size_o); end
            step();
        end
        gnt_i = 1'b1;
        #1;
        tests++; if (req_o !== 1'b1 || empty_o !== 1'b0) begin fails++; $display("FAIL stall_grant_cycle got req=%0b empty=%0b want 1/0", req_o, empty_o); end
        step();
        tests++; if (empty_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL stall_freed got empty=%0b req=%0b want 1/0", empty_o, req_o); end
    endtask

    task automatic test_timeout_race();
        gnt_i = 1'b1;
        put(56'h5000, 64'h0000_0000_0000_0011, 8'h01, 2'd0);
        step();
        idle_in();
        repeat (8) step();
        put(56'h5001, 64'h0000_0000_0000_2200, 8'h02, 2'd0);
        #1;
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL race_ready got %0b want 0", ready_o); end
        step();
        tests++; if (req_o !== 1'b1 || be_o !== 8'h01 || size_o !== 2'd0 || wdata_o !== 64'h11 || ready_o !== 1'b0) begin fails++; $display("FAIL race_unmerged got req=%0b rdy=%0b %h/%0d/%h want 1 0 01/0/11", req_o, ready_o, be_o, size_o, wdata_o); end
        step();
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL race_accept got %0b want 1", ready_o); end
        step();
        idle_in();
        drain_i = 1'b1;
        step();
        drain_i = 1'b0;
        #1;
        tests++; if (req_o !== 1'b1 || addr_o !== 56'h5000 || be_o !== 8'h02 || size_o !== 2'd0 || wdata_o !== 64'h2200) begin fails++; $display("FAIL race_second got req=%0b %h/%h/%0d/%h want 1 5000/02/0/2200", req_o, addr_o, be_o, size_o, wdata_o); end
        step();
    endtask

    task automatic test_reset_mid_issue();
`ifdef STORE_COALESCE_STATS_EN
        tests++; if (stat_merges_o !== 32'd1 || stat_issues_o !== 32'd7) begin fails++; $display("FAIL stats_count got %0d/%0d want 1/7", stat_merges_o, stat_issues_o); end
`endif
        gnt_i = 1'b0;
        put(56'h6000, 64'h55, 8'h01, 2'd0);
        step();
        idle_in();
        drain_i = 1'b1;
        step();
        drain_i = 1'b0;
        tests++; if (req_o !== 1'b1) begin fails++; $display("FAIL rst_pre_req got %0b want 1", req_o); end
        #1;
        rst_ni = 1'b0;
        #1;
        tests++; if (req_o !== 1'b0 || empty_o !== 1'b1) begin fails++; $display("FAIL rst_mid got req=%0b empty=%0b want 0/1", req_o, empty_o); end
`ifdef STORE_COALESCE_STATS_EN
        tests++; if ({stat_merges_o, stat_issues_o} !== 64'd0) begin fails++; $display("FAIL rst_stats got %0d/%0d want 0/0", stat_merges_o, stat_issues_o); end
`endif
        #4;
        rst_ni = 1'b1;
        gnt_i = 1'b1;
        step();
        tests++; if (ready_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL rst_after got rdy=%0b req=%0b want 1/0", ready_o, req_o); end
    endtask

    initial begin
        test_reset();
        test_single_timeout();
        test_merge_drain();
        test_back_to_back();
        test_gnt_stall();
        test_timeout_race();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
